// File: rtl/bf_pkg.sv
// Shared opcode, error-code and state definitions for the Brainfuck program loader.
package bf_pkg;

    localparam int OP_W = 4;

    typedef logic [OP_W-1:0] opcode_t;

    // Instruction format is {tape_in, ptr_in, stack_op, inc_dec}
    localparam opcode_t OP_INC   = 4'b1001;
    localparam opcode_t OP_DEC   = 4'b1000;
    localparam opcode_t OP_RIGHT = 4'b0101;
    localparam opcode_t OP_LEFT  = 4'b0100;
    localparam opcode_t OP_OPEN  = 4'b0010;
    localparam opcode_t OP_CLOSE = 4'b0011;
    localparam opcode_t OP_NOP   = 4'b0000;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_CLOSE = 2'd1;
    localparam logic [1:0] ERR_OPEN  = 2'd2;
    localparam logic [1:0] ERR_LIMIT = 2'd3;

    typedef enum logic [2:0] {
        PREP  = 3'd0,
        LOAD  = 3'd1,
        FILL  = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } state_t;

endpackage

// File: rtl/bf_decode.sv
// Combinational ASCII-to-instruction decoder; non-command bytes are comments.
module bf_decode
    import bf_pkg::*;
(
    input  logic [7:0] src_byte,
    output logic       is_cmd,
    output opcode_t    opcode,
    output logic       is_open,
    output logic       is_close
);

    // Map each command character to its opcode and bracket flags
    always_comb begin
        is_cmd   = 1'b1;
        opcode   = OP_NOP;
        is_open  = 1'b0;
        is_close = 1'b0;
        case (src_byte)
            8'h2B: opcode = OP_INC;
            8'h2D: opcode = OP_DEC;
            8'h3E: opcode = OP_RIGHT;
            8'h3C: opcode = OP_LEFT;
            8'h5B: begin
                opcode  = OP_OPEN;
                is_open = 1'b1;
            end
            8'h5D: begin
                opcode   = OP_CLOSE;
                is_close = 1'b1;
            end
            default: is_cmd = 1'b0;
        endcase
    end

endmodule

// File: rtl/bf_loader.sv
// Streams ASCII Brainfuck into program memory, checks bracket balance and
// depth, zero-fills the tail, then releases the core.
module bf_loader
    import bf_pkg::*;
#(
    parameter int PRG_AW   = 8,
    parameter int INSTR_W  = OP_W,
    parameter int STACK_AW = 4
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_src_valid,
    input  logic [7:0]         i_src_data,
    input  logic               i_src_last,
    output logic               o_src_ready,
    output logic               o_prgmem_we,
    output logic [PRG_AW-1:0]  o_prgmem_addr,
    output logic [INSTR_W-1:0] o_prgmem_data,
    output logic               o_core_run,
    output logic               o_error,
    output logic [1:0]         o_error_code,
    output logic [PRG_AW-1:0]  o_prog_len
);

    localparam int                  DEPTH_W   = STACK_AW + 1;
    localparam logic [DEPTH_W-1:0]  DEPTH_MAX = {1'b1, {STACK_AW{1'b0}}};
    localparam logic [PRG_AW-1:0]   LEN_MAX   = {PRG_AW{1'b1}};

    state_t               state_r, state_nxt_s;
    logic [PRG_AW-1:0]    wptr_r, wptr_nxt_s;
    logic [PRG_AW-1:0]    len_r, len_nxt_s;
    logic [DEPTH_W-1:0]   depth_r, depth_nxt_s;
    logic                 we_r, we_nxt_s;
    logic [PRG_AW-1:0]    addr_r, addr_nxt_s;
    logic [INSTR_W-1:0]   data_r, data_nxt_s;
    logic                 ready_r, ready_nxt_s;
    logic                 run_r, run_nxt_s;
    logic                 error_r, error_nxt_s;
    logic [1:0]           code_r, code_nxt_s;

    logic                 xfer_s;
    logic                 dec_is_cmd_s;
    opcode_t              dec_opcode_s;
    logic                 dec_is_open_s;
    logic                 dec_is_close_s;

    bf_decode u_decode (
        .src_byte (i_src_data),
        .is_cmd   (dec_is_cmd_s),
        .opcode   (dec_opcode_s),
        .is_open  (dec_is_open_s),
        .is_close (dec_is_close_s)
    );

    assign xfer_s = i_src_valid && ready_r;

    // Next-state and next-output logic for the load sequence
    always_comb begin
        state_nxt_s = state_r;
        wptr_nxt_s  = wptr_r;
        len_nxt_s   = len_r;
        depth_nxt_s = depth_r;
        we_nxt_s    = 1'b0;
        addr_nxt_s  = addr_r;
        data_nxt_s  = data_r;
        error_nxt_s = error_r;
        code_nxt_s  = code_r;
        case (state_r)
            PREP: begin
                we_nxt_s    = 1'b1;
                addr_nxt_s  = {PRG_AW{1'b0}};
                data_nxt_s  = INSTR_W'(OP_NOP);
                wptr_nxt_s  = {{(PRG_AW-1){1'b0}}, 1'b1};
                len_nxt_s   = {PRG_AW{1'b0}};
                depth_nxt_s = {DEPTH_W{1'b0}};
                state_nxt_s = LOAD;
            end
            LOAD: begin
                if (xfer_s) begin
                    if (dec_is_close_s && (depth_r == {DEPTH_W{1'b0}})) begin
                        state_nxt_s = ERROR;
                        error_nxt_s = 1'b1;
                        code_nxt_s  = ERR_CLOSE;
                    end else if (dec_is_cmd_s && ((len_r == LEN_MAX) ||
                                 (dec_is_open_s && (depth_r == DEPTH_MAX)))) begin
                        state_nxt_s = ERROR;
                        error_nxt_s = 1'b1;
                        code_nxt_s  = ERR_LIMIT;
                    end else begin
                        if (dec_is_cmd_s) begin
                            we_nxt_s   = 1'b1;
                            addr_nxt_s = wptr_r;
                            data_nxt_s = INSTR_W'(dec_opcode_s);
                            wptr_nxt_s = wptr_r + PRG_AW'(1);
                            len_nxt_s  = len_r + PRG_AW'(1);
                            if (dec_is_open_s) begin
                                depth_nxt_s = depth_r + DEPTH_W'(1);
                            end else if (dec_is_close_s) begin
                                depth_nxt_s = depth_r - DEPTH_W'(1);
                            end else begin
                                depth_nxt_s = depth_r;
                            end
                        end else begin
                            we_nxt_s = 1'b0;
                        end
                        // The last byte is processed first, then balance decides the exit
                        if (i_src_last) begin
                            if (depth_nxt_s != {DEPTH_W{1'b0}}) begin
                                state_nxt_s = ERROR;
                                error_nxt_s = 1'b1;
                                code_nxt_s  = ERR_OPEN;
                            end else if (len_nxt_s == LEN_MAX) begin
                                state_nxt_s = DONE;
                            end else begin
                                state_nxt_s = FILL;
                            end
                        end else begin
                            state_nxt_s = LOAD;
                        end
                    end
                end else begin
                    we_nxt_s = 1'b0;
                end
            end
            FILL: begin
                we_nxt_s   = 1'b1;
                addr_nxt_s = wptr_r;
                data_nxt_s = INSTR_W'(OP_NOP);
                wptr_nxt_s = wptr_r + PRG_AW'(1);
                if (wptr_r == LEN_MAX) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = FILL;
                end
            end
            DONE:    state_nxt_s = DONE;
            ERROR:   state_nxt_s = ERROR;
            default: state_nxt_s = PREP;
        endcase
        // Ready opens one cycle after entering LOAD and closes on the exit edge
        ready_nxt_s = (state_r == LOAD) && (state_nxt_s == LOAD);
        run_nxt_s   = (state_nxt_s == DONE);
    end

    // State register
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_r <= PREP;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath and output registers
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            wptr_r  <= {PRG_AW{1'b0}};
            len_r   <= {PRG_AW{1'b0}};
            depth_r <= {DEPTH_W{1'b0}};
            we_r    <= 1'b0;
            addr_r  <= {PRG_AW{1'b0}};
            data_r  <= {INSTR_W{1'b0}};
            ready_r <= 1'b0;
            run_r   <= 1'b0;
            error_r <= 1'b0;
            code_r  <= ERR_NONE;
        end else begin
            wptr_r  <= wptr_nxt_s;
            len_r   <= len_nxt_s;
            depth_r <= depth_nxt_s;
            we_r    <= we_nxt_s;
            addr_r  <= addr_nxt_s;
            data_r  <= data_nxt_s;
            ready_r <= ready_nxt_s;
            run_r   <= run_nxt_s;
            error_r <= error_nxt_s;
            code_r  <= code_nxt_s;
        end
    end

    assign o_src_ready   = ready_r;
    assign o_prgmem_we   = we_r;
    assign o_prgmem_addr = addr_r;
    assign o_prgmem_data = data_r;
    assign o_core_run    = run_r;
    assign o_error       = error_r;
    assign o_error_code  = code_r;
    assign o_prog_len    = len_r;

endmodule
